// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: operations, frame header
// tag and sequencer state encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } operation_t;

    localparam logic [5:0] HDR_TAG = 6'b110000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_GET_B = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_RESP  = 3'd5
    } seq_state_t;

    function automatic logic hdr_ok(input logic [7:0] b);
        return (b[7:2] == HDR_TAG) && (b[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// Inter-byte timeout down-counter: reloads on i_clr, counts while i_en,
// pulses o_expire on its last enabled cycle. Built only with ALU_SEQ_TIMEOUT_EN.
`ifdef ALU_SEQ_TIMEOUT_EN
module alu_seq_timer #(
    parameter int CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LOADV = CW'(CYCLES);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= LOADV;
        end else if (i_clr) begin
            r_cnt <= LOADV;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_expire = i_en && !i_clr && (r_cnt == CW'(1));

endmodule
`endif

// File: rtl/alu_cmd_seq.sv
// Frames UART bytes into ALU commands and returns the result byte.
// Optional inter-byte timeout is enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int WIDTH          = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_in_valid,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_out_valid,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             err
);

    if (WIDTH < 1 || WIDTH > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("alu_cmd_seq: illegal WIDTH or TIMEOUT_CYCLES");
    end

    seq_state_t       r_state;
    seq_state_t       w_next;
    operation_t       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [7:0]       r_tx;
    logic             r_err;
    logic             w_err;
    logic             w_expire;
    logic             w_hdr_ok;

    assign w_hdr_ok = hdr_ok(rx_data);

`ifdef ALU_SEQ_TIMEOUT_EN
    logic w_tmr_en;
    logic w_tmr_clr;

    assign w_tmr_en  = (r_state == S_GET_A) || (r_state == S_GET_B);
    assign w_tmr_clr = rx_valid || !w_tmr_en;

    alu_seq_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err;
        end
    end

    // Bytes arriving after the frame is complete are overruns.
    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (w_hdr_ok) w_next = S_GET_A;
                    else          w_err  = 1'b1;
                end
            end
            S_GET_A: begin
                if (rx_valid) begin
                    w_next = S_GET_B;
                end else if (w_expire) begin
                    w_next = S_IDLE;
                    w_err  = 1'b1;
                end
            end
            S_GET_B: begin
                if (rx_valid) begin
                    w_next = S_ISSUE;
                end else if (w_expire) begin
                    w_next = S_IDLE;
                    w_err  = 1'b1;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
                w_err  = rx_valid;
            end
            S_WAIT: begin
                if (alu_out_valid) w_next = S_RESP;
                w_err = rx_valid;
            end
            S_RESP: begin
                if (tx_ready) w_next = S_IDLE;
                w_err = rx_valid;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op <= OP_NOP;
            r_a  <= '0;
            r_b  <= '0;
            r_tx <= '0;
        end else begin
            if (r_state == S_IDLE && rx_valid && w_hdr_ok)
                r_op <= operation_t'(rx_data[1:0]);
            if (r_state == S_GET_A && rx_valid)
                r_a <= rx_data[WIDTH-1:0];
            if (r_state == S_GET_B && rx_valid)
                r_b <= rx_data[WIDTH-1:0];
            if (r_state == S_WAIT && alu_out_valid)
                r_tx <= 8'(alu_out);
        end
    end

    always_comb begin
        alu_op       = r_op;
        alu_a        = r_a;
        alu_b        = r_b;
        alu_in_valid = (r_state == S_ISSUE);
        tx_data      = r_tx;
        tx_valid     = (r_state == S_RESP);
        busy         = (r_state != S_IDLE);
        err          = r_err;
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Scoreboard bench for alu_cmd_seq with a 2-cycle add/sub ALU model.
// Timeout scenario runs only when ALU_SEQ_TIMEOUT_EN is defined.
module tb_alu_cmd_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [1:0] alu_op;
    logic [5:0] alu_a;
    logic [5:0] alu_b;
    logic       alu_in_valid;
    logic [5:0] alu_out;
    logic       alu_out_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t_last = 0;
    int n_err = 0;
    int exp_err = 0;
    logic txv_prev = 1'b0;
    logic seen;

    typedef struct {
        logic [1:0] op;
        logic [5:0] a;
        logic [5:0] b;
        int         t;
    } iss_t;

    iss_t       iq[$];
    logic [7:0] tq[$];
    iss_t       ie;
    logic [7:0] te;

    alu_cmd_seq #(
        .WIDTH          (6),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_in_valid  (alu_in_valid),
        .alu_out       (alu_out),
        .alu_out_valid (alu_out_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic       p1_v;
    logic [1:0] p1_op;
    logic [5:0] p1_a;
    logic [5:0] p1_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_v <= 1'b0;
            p1_op <= 2'd0;
            p1_a <= 6'd0;
            p1_b <= 6'd0;
            alu_out_valid <= 1'b0;
            alu_out <= 6'd0;
        end else begin
            p1_v <= alu_in_valid;
            p1_op <= alu_op;
            p1_a <= alu_a;
            p1_b <= alu_b;
            alu_out_valid <= p1_v;
            case (p1_op)
                2'd1:    alu_out <= p1_a + p1_b;
                2'd2:    alu_out <= p1_a - p1_b;
                default: alu_out <= 6'd0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (alu_in_valid) begin
                if (iq.size() == 0) begin
                    chk("unexpected_issue", 32'(1), 32'(0));
                end else begin
                    ie = iq.pop_front();
                    chk("issue_op", 32'(alu_op), 32'(ie.op));
                    chk("issue_a", 32'(alu_a), 32'(ie.a));
                    chk("issue_b", 32'(alu_b), 32'(ie.b));
                    chk("issue_lat", 32'(cyc), 32'(ie.t + 1));
                end
            end
            if (tx_valid && !txv_prev)
                chk("tx_lat", 32'(cyc), 32'(t_last + 4));
            if (tx_valid && tx_ready) begin
                if (tq.size() == 0) begin
                    chk("unexpected_tx", 32'(tx_data), 32'hFFFF);
                end else begin
                    te = tq.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(te));
                end
            end
            if (err) n_err++;
        end
        txv_prev = tx_valid;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] a,
                              input logic [7:0] b, input logic [1:0] eop,
                              input logic [5:0] ea, input logic [5:0] eb,
                              input logic [7:0] etx, input bit want_tx);
        iss_t e;
        send_byte(h);
        send_byte(a);
        e.op = eop;
        e.a = ea;
        e.b = eb;
        e.t = cyc;
        iq.push_back(e);
        if (want_tx) tq.push_back(etx);
        t_last = cyc;
        send_byte(b);
    endtask

    task automatic wait_hs();
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) seen = 1'b1;
        end
        chk("hs_timeout", 32'(seen), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("reset_outs", 32'({alu_op, alu_a, alu_b, alu_in_valid, tx_data,
                               tx_valid, busy, err}), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        send_frame(8'hC1, 8'h05, 8'h03, 2'd1, 6'd5, 6'd3, 8'h08, 1'b1);
        wait_hs();
        send_frame(8'hC2, 8'h03, 8'h05, 2'd2, 6'd3, 6'd5, 8'h3E, 1'b1);
        wait_hs();
        send_frame(8'hC1, 8'hFF, 8'h41, 2'd1, 6'h3F, 6'h01, 8'h00, 1'b1);
        wait_hs();
        send_frame(8'hC0, 8'h00, 8'h00, 2'd0, 6'd0, 6'd0, 8'h00, 1'b1);
        wait_hs();
        chk("b2b_busy", 32'(busy), 32'(0));

        send_byte(8'h41);
        exp_err++;
        chk("hdr_bad_busy", 32'(busy), 32'(0));
        send_byte(8'hC3);
        exp_err++;
        chk("hdr_op3_busy", 32'(busy), 32'(0));
        idle(2);
        chk("hdr_busy", 32'(busy), 32'(0));
        chk("hdr_err_cnt", 32'(n_err), 32'(exp_err));

        tx_ready = 1'b0;
        send_frame(8'hC1, 8'h0A, 8'h07, 2'd1, 6'd10, 6'd7, 8'h11, 1'b1);
        idle(3);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                send_byte(8'hC1);
                exp_err++;
            end else begin
                idle(1);
            end
            chk("bp_valid", 32'(tx_valid), 32'(1));
            chk("bp_data", 32'(tx_data), 32'h11);
        end
        tx_ready = 1'b1;
        wait_hs();
        chk("bp_idle_busy", 32'(busy), 32'(0));
        chk("bp_idle_valid", 32'(tx_valid), 32'(0));
        chk("bp_err_cnt", 32'(n_err), 32'(exp_err));

`ifdef ALU_SEQ_TIMEOUT_EN
        send_byte(8'hC1);
        send_byte(8'h05);
        idle(60);
        exp_err++;
        chk("tmo_busy", 32'(busy), 32'(0));
        chk("tmo_err_cnt", 32'(n_err), 32'(exp_err));
        send_frame(8'hC1, 8'h02, 8'h03, 2'd1, 6'd2, 6'd3, 8'h05, 1'b1);
        wait_hs();
`endif

        send_frame(8'hC1, 8'h01, 8'h01, 2'd1, 6'd1, 6'd1, 8'h02, 1'b0);
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_outs", 32'({alu_op, alu_a, alu_b, alu_in_valid, tx_data,
                                  tx_valid, busy, err}), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);
        chk("rst_no_resp", 32'(tx_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));

        send_frame(8'hC2, 8'h10, 8'h01, 2'd2, 6'h10, 6'h01, 8'h0F, 1'b1);
        wait_hs();
        idle(3);
        chk("iq_empty", 32'(iq.size()), 32'(0));
        chk("tq_empty", 32'(tq.size()), 32'(0));
        chk("err_total", 32'(n_err), 32'(exp_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer between the UART receiver and the registered add/sub ALU. It assembles 3-byte command frames (opcode, A, B) from the UART byte stream and issues one ALU operation per frame. It waits for the ALU result and hands it to the UART transmit path as one byte over a valid/ready handshake. It is the only driver of the ALU inputs.

## Interface
- WIDTH, 6, ALU operand/result width; legal range 1..8
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles (used only with ALU_SEQ_TIMEOUT_EN)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  received byte, valid only while rx_valid is high
- rx_valid  in  1  one-cycle pulse per received byte
- alu_op  out  2  operation_t to ALU (nop=0, add=1, sub=2)
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_in_valid  out  1  one-cycle issue strobe to ALU
- alu_out  in  WIDTH  ALU result
- alu_out_valid  in  1  ALU result strobe
- tx_data  out  8  response byte
- tx_valid  out  1  response valid, held until accepted
- tx_ready  in  1  transmit path accepts tx_data when tx_valid && tx_ready
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on any protocol error

## Operation
- Frame format: byte0 = {6'b110000, op}; byte1 = A; byte2 = B. Operands use byte[WIDTH-1:0]; the upper bits are ignored.
- FSM states: IDLE, GET_A, GET_B, ISSUE, WAIT, RESP.
- IDLE -> GET_A on rx_valid with a valid header and op in {0,1,2}.
- IDLE stays in IDLE on rx_valid with a bad header (byte0[7:2] != 6'b110000) or op==3. The byte is discarded and err pulses.
- GET_A -> GET_B on rx_valid; A is latched.
- GET_B -> ISSUE on rx_valid; B is latched.
- ISSUE: alu_in_valid=1 for exactly one cycle, with alu_op/alu_a/alu_b driven from the latched values. Next state is WAIT.
- alu_op/alu_a/alu_b hold their latched values outside ISSUE. They are 0 after reset.
- WAIT -> RESP on alu_out_valid. tx_data is latched as zero-extended alu_out.
- RESP: tx_valid=1 and tx_data held stable until tx_ready. On the handshake cycle the state goes to IDLE and tx_valid drops on the next cycle.
- Arithmetic is performed by the ALU: add and sub wrap modulo 2^WIDTH, and nop returns 0. The sequencer does no arithmetic.
- Overrun: rx_valid in ISSUE, WAIT or RESP drops the byte and pulses err. The state is unaffected.
- Reset values: all outputs 0, state IDLE, latched op/A/B cleared. Reset mid-frame or mid-response abandons the frame; no response byte is produced.

## Timing
- Last frame byte (rx_valid) in cycle T -> alu_in_valid in cycle T+1.
- With the 2-cycle ALU, alu_out_valid arrives in T+3 and tx_valid goes high in T+4.
- err is registered and goes high in the cycle after the offending rx_valid.
- A new header is accepted in the cycle after the tx handshake. Back-to-back frames are supported without idle gaps.
- tx_valid never depends combinationally on tx_ready.

## Configuration
- ALU_SEQ_TIMEOUT_EN defined: a counter clears on every accepted byte in GET_A/GET_B. If it reaches TIMEOUT_CYCLES while in GET_A or GET_B, the state returns to IDLE, the partial frame is dropped and err pulses. The counter is idle in all other states.
- ALU_SEQ_TIMEOUT_EN undefined: no counter is instantiated, and GET_A/GET_B wait indefinitely. The TIMEOUT_CYCLES parameter is ignored.

## Structure
- Shared package alu_pkg holds: operation_t (nop/add/sub), the header constant 6'b110000, and the sequencer state enum.
- One sub-module, alu_seq_timer: a loadable down-counter with a clear input and an expire pulse, instantiated only under ALU_SEQ_TIMEOUT_EN.

## Test plan
- Add frame: send 0xC1, 0x05, 0x03 with tx_ready=1 -> one alu_in_valid with op=add, a=5, b=3; tx_data=0x08 with tx_valid asserted in T+4.
- Sub wrap: send 0xC2, 0x03, 0x05 (WIDTH=6) -> tx_data=0x3E.
- Header check: send 0x41, then 0xC3 -> two err pulses, no alu_in_valid, busy stays 0.
- Send a full frame 0xC0, 0x00, 0x00 (nop) -> tx_data=0x00.
- Backpressure/overrun: send a frame with tx_ready=0 for 10 cycles, and inject rx_valid (0xC1) during RESP -> tx_data/tx_valid stable for those 10 cycles; the injected byte raises err and is dropped; IDLE follows the handshake.
- Timeout (macro defined, TIMEOUT_CYCLES=50): send 0xC1, 0x05, then idle 60 cycles -> err pulse, busy=0. A following full frame is answered correctly. Separately, assert rst during WAIT -> all outputs 0 and no response.
